// File: rtl/compound_alu_if.sv
// Command/response bundle for the compound accumulator ALU.
// The master side issues commands and accepts results; the slave side is the ALU.
interface compound_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_operand;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_div_by_zero;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, in_op, in_operand, out_ready,
    input  in_ready, out_valid, out_result, out_div_by_zero, acc
  );

  modport slave (
    input  in_valid, in_op, in_operand, out_ready,
    output in_ready, out_valid, out_result, out_div_by_zero, acc
  );
endinterface

// File: rtl/compound_alu.sv
// Accumulator ALU: one command in flight, single-cycle ADD/SUB/MUL/LOAD,
// multi-cycle signed DIV/MOD via a restoring shift-subtract divider on magnitudes.
module compound_alu #(
  parameter int WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  compound_alu_if.slave   alu_bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_LOAD = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVIDE  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  // Magnitude of a two's-complement value; the most-negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_dbz;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_is_mod;
  logic             r_q_neg;
  logic             r_r_neg;

  logic             w_accept;
  logic             w_is_divop;
  logic             w_zero_opnd;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_div_res;

  assign w_accept    = alu_bus.in_valid && (r_state == S_IDLE);
  assign w_is_divop  = (alu_bus.in_op == OP_DIV) || (alu_bus.in_op == OP_MOD);
  assign w_zero_opnd = (alu_bus.in_operand == '0);

  assign alu_bus.in_ready        = (r_state == S_IDLE);
  assign alu_bus.out_valid       = r_out_valid;
  assign alu_bus.out_result      = r_out_result;
  assign alu_bus.out_div_by_zero = r_out_dbz;
  assign alu_bus.acc             = r_acc;

  // Single-cycle result; reserved ops and DIV/MOD leave the accumulator as is here.
  always_comb begin
    w_alu_res = r_acc;
    case (alu_bus.in_op)
      OP_ADD:  w_alu_res = r_acc + alu_bus.in_operand;
      OP_SUB:  w_alu_res = r_acc - alu_bus.in_operand;
      OP_MUL:  w_alu_res = r_acc * alu_bus.in_operand;
      OP_LOAD: w_alu_res = alu_bus.in_operand;
      default: w_alu_res = r_acc;
    endcase
  end

  // One restoring-division step plus sign fix-up of the final quotient/remainder.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_div};
    if (w_diff[WIDTH] == 1'b0) begin
      w_rem_nxt = w_diff[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_nxt = w_shift[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
    end
    if (r_is_mod) begin
      w_div_res = r_r_neg ? -w_rem_nxt : w_rem_nxt;
    end else begin
      w_div_res = r_q_neg ? -w_quo_nxt : w_quo_nxt;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_divop && !w_zero_opnd) begin
            w_next_state = S_DIVIDE;
          end else begin
            w_next_state = S_RESPOND;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_DIVIDE: begin
        if (r_cnt == CNT_LAST) begin
          w_next_state = S_RESPOND;
        end else begin
          w_next_state = S_DIVIDE;
        end
      end
      S_RESPOND: begin
        if (alu_bus.out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESPOND;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Accumulator, divider and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_dbz    <= 1'b0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_div        <= '0;
      r_cnt        <= '0;
      r_is_mod     <= 1'b0;
      r_q_neg      <= 1'b0;
      r_r_neg      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_divop && w_zero_opnd) begin
            r_out_valid  <= 1'b1;
            r_out_result <= r_acc;
            r_out_dbz    <= 1'b1;
          end else if (w_accept && w_is_divop) begin
            r_rem    <= '0;
            r_quo    <= abs_mag(r_acc);
            r_div    <= abs_mag(alu_bus.in_operand);
            r_cnt    <= '0;
            r_is_mod <= (alu_bus.in_op == OP_MOD);
            r_q_neg  <= r_acc[WIDTH-1] ^ alu_bus.in_operand[WIDTH-1];
            r_r_neg  <= r_acc[WIDTH-1];
          end else if (w_accept) begin
            r_acc        <= w_alu_res;
            r_out_valid  <= 1'b1;
            r_out_result <= w_alu_res;
            r_out_dbz    <= 1'b0;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_acc        <= w_div_res;
            r_out_valid  <= 1'b1;
            r_out_result <= w_div_res;
            r_out_dbz    <= 1'b0;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        S_RESPOND: begin
          if (alu_bus.out_ready) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_dbz    <= 1'b0;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_out_valid  <= 1'b0;
          r_out_result <= '0;
          r_out_dbz    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compound_alu.sv
// Randomized plus directed bench for compound_alu against a plain-arithmetic reference model.
module tb_compound_alu;

  localparam int W = 32;
  localparam int INT_MIN = int'(32'h8000_0000);

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;
  int model_acc;

  compound_alu_if #(.WIDTH(W)) alu_bus();

  compound_alu #(.WIDTH(W)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .alu_bus (alu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour: result, divide-by-zero flag and accept-to-valid latency.
  function automatic void ref_cmd(input int op, input int acc_in, input int opnd,
                                  output int res, output bit dbz, output int lat);
    dbz = 1'b0;
    lat = 1;
    res = acc_in;
    case (op)
      0: res = acc_in + opnd;
      1: res = acc_in - opnd;
      2: res = acc_in * opnd;
      3, 4: begin
        if (opnd == 0) begin
          dbz = 1'b1;
        end else begin
          lat = W + 1;
          if (acc_in == INT_MIN && opnd == -1) res = (op == 3) ? INT_MIN : 0;
          else if (op == 3) res = acc_in / opnd;
          else res = acc_in % opnd;
        end
      end
      5: res = opnd;
      default: res = acc_in;
    endcase
  endfunction

  // Issue one command from a negedge, check latency/response/backpressure, end on a negedge.
  task automatic run_cmd(input string tag, input logic [2:0] op, input int opnd, input int hold);
    int  exp_res;
    int  exp_lat;
    int  lat;
    int  pre_acc;
    bit  exp_dbz;
    check_eq({tag, ".in_ready"}, {31'd0, alu_bus.in_ready}, 32'd1);
    ref_cmd(int'(op), model_acc, opnd, exp_res, exp_dbz, exp_lat);
    pre_acc = model_acc;
    alu_bus.in_valid   = 1'b1;
    alu_bus.in_op      = op;
    alu_bus.in_operand = opnd;
    alu_bus.out_ready  = (hold == 0);
    @(posedge clk);
    #1;
    alu_bus.in_valid   = 1'($urandom_range(0, 1));
    alu_bus.in_op      = 3'($urandom);
    alu_bus.in_operand = $urandom;
    lat = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (alu_bus.out_valid === 1'b1) break;
      check_eq({tag, ".busy_ready"}, {31'd0, alu_bus.in_ready}, 32'd0);
      check_eq({tag, ".acc_stable"}, alu_bus.acc, pre_acc);
      check_eq({tag, ".dbz_idle"}, {31'd0, alu_bus.out_div_by_zero}, 32'd0);
      @(posedge clk);
      lat++;
    end
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".result"}, alu_bus.out_result, exp_res);
    check_eq({tag, ".dbz"}, {31'd0, alu_bus.out_div_by_zero}, {31'd0, exp_dbz});
    check_eq({tag, ".acc"}, alu_bus.acc, exp_res);
    model_acc = exp_res;
    for (int k = 0; k < hold; k++) begin
      check_eq({tag, ".hold_valid"}, {31'd0, alu_bus.out_valid}, 32'd1);
      check_eq({tag, ".hold_result"}, alu_bus.out_result, exp_res);
      check_eq({tag, ".hold_ready"}, {31'd0, alu_bus.in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    alu_bus.out_ready = 1'b1;
    check_eq({tag, ".resp_ready"}, {31'd0, alu_bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    alu_bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, ".done_valid"}, {31'd0, alu_bus.out_valid}, 32'd0);
    check_eq({tag, ".done_dbz"}, {31'd0, alu_bus.out_div_by_zero}, 32'd0);
    check_eq({tag, ".done_ready"}, {31'd0, alu_bus.in_ready}, 32'd1);
  endtask

  initial begin
    int sel;
    int opnd;
    logic [2:0] op;
    n_checks  = 0;
    n_errors  = 0;
    model_acc = 0;
    alu_bus.in_valid   = 1'b0;
    alu_bus.in_op      = 3'd0;
    alu_bus.in_operand = 32'd0;
    alu_bus.out_ready  = 1'b1;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst.state_ready", {31'd0, alu_bus.in_ready}, 32'd1);
    check_eq("rst.acc", alu_bus.acc, 32'd0);
    check_eq("rst.out_valid", {31'd0, alu_bus.out_valid}, 32'd0);
    check_eq("rst.out_result", alu_bus.out_result, 32'd0);
    check_eq("rst.dbz", {31'd0, alu_bus.out_div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst.first_edge_ready", {31'd0, alu_bus.in_ready}, 32'd1);
    @(negedge clk);

    // Chain with out_ready high.
    run_cmd("chain.load", 3'd5, 7, 0);
    run_cmd("chain.add", 3'd0, 13, 0);
    run_cmd("chain.sub", 3'd1, 13, 0);
    run_cmd("chain.mul", 3'd2, 13, 0);
    run_cmd("chain.div", 3'd3, 13, 0);
    run_cmd("chain.mod", 3'd4, 13, 0);
    check_eq("chain.final", alu_bus.acc, 32'd7);

    // Signed divide and modulo corners.
    run_cmd("sdiv.load", 3'd5, -7, 0);
    run_cmd("sdiv.div", 3'd3, 2, 0);
    check_eq("sdiv.m7d2", alu_bus.acc, -32'sd3);
    run_cmd("smod.load", 3'd5, -7, 0);
    run_cmd("smod.mod", 3'd4, 2, 0);
    check_eq("smod.m7m2", alu_bus.acc, -32'sd1);
    run_cmd("smod2.load", 3'd5, 7, 0);
    run_cmd("smod2.mod", 3'd4, -2, 0);
    check_eq("smod2.7mm2", alu_bus.acc, 32'd1);
    run_cmd("mindiv.load", 3'd5, INT_MIN, 0);
    run_cmd("mindiv.div", 3'd3, -1, 0);
    check_eq("mindiv.res", alu_bus.acc, 32'h8000_0000);
    run_cmd("minmod.load", 3'd5, INT_MIN, 0);
    run_cmd("minmod.mod", 3'd4, -1, 0);
    check_eq("minmod.res", alu_bus.acc, 32'd0);

    // Divide by zero, then a normal op.
    run_cmd("dz.load", 3'd5, 5, 0);
    run_cmd("dz.div0", 3'd3, 0, 0);
    run_cmd("dz.mod0", 3'd4, 0, 1);
    run_cmd("dz.add", 3'd0, 1, 0);
    check_eq("dz.after", alu_bus.acc, 32'd6);

    // Backpressure with wrap.
    run_cmd("bp.load", 3'd5, 32'h7fff_ffff, 0);
    run_cmd("bp.add", 3'd0, 1, 10);
    check_eq("bp.wrap", alu_bus.acc, 32'h8000_0000);
    run_cmd("bp.reserved", 3'd6, 1234, 3);

    // Reset in the middle of a divide abandons the command.
    run_cmd("rmid.load", 3'd5, 100, 0);
    alu_bus.in_valid   = 1'b1;
    alu_bus.in_op      = 3'd3;
    alu_bus.in_operand = 32'd3;
    @(posedge clk);
    #1;
    alu_bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rmid.acc", alu_bus.acc, 32'd0);
    check_eq("rmid.ready", {31'd0, alu_bus.in_ready}, 32'd1);
    check_eq("rmid.valid", {31'd0, alu_bus.out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("rmid.valid_low", {31'd0, alu_bus.out_valid}, 32'd0);
    end
    rst_n = 1'b1;
    model_acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      check_eq("rmid.no_resp", {31'd0, alu_bus.out_valid}, 32'd0);
      check_eq("rmid.ready_after", {31'd0, alu_bus.in_ready}, 32'd1);
    end
    @(negedge clk);
    run_cmd("rmid.add", 3'd0, 4, 0);
    check_eq("rmid.add_res", alu_bus.acc, 32'd4);

    // Randomized commands with corner-biased operands.
    for (int n = 0; n < 120; n++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 6);
      case (sel)
        0: opnd = 0;
        1: opnd = -1;
        2: opnd = INT_MIN;
        3: opnd = $urandom_range(1, 20);
        4: opnd = -int'($urandom_range(1, 20));
        default: opnd = int'($urandom);
      endcase
      run_cmd("rand", op, opnd, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
